// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: FSM states and the
// operation latched at grant time.
package mem_arbiter_pkg;

  // Transaction life cycle; exactly one transaction is in flight at a time.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  // Operation carried by the granted request.
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // A requester raising read and write together is served as a read.
  function automatic op_t decode_op(input logic rd);
    return rd ? OP_READ : OP_WRITE;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin pick. With a single request
// the requester wins outright; with both requesting, the one not granted last
// wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

  // Grant index selection; the value is only consumed when req is non-zero.
  always_comb begin
    // NOTE: every path assigns grant, starting from a default, so no latch is inferred.
    grant = 1'b0;
    if (&req) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between a cpu (r0) and a video/DMA
// engine (r1). Requests are levels held until done; the arbiter grants one,
// issues a one-cycle dispatch, waits for mem_done (bounded by TIMEOUT) and
// returns a one-cycle completion pulse to the granted requester only.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_in,
  input  logic              rst_in,
  // requester 0 (cpu)
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_write_data,
  input  logic              r0_read,
  input  logic              r0_write,
  output logic [DATA_W-1:0] r0_read_data,
  output logic              r0_done,
  output logic              r0_error,
  // requester 1 (video/DMA)
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_write_data,
  input  logic              r1_read,
  input  logic              r1_write,
  output logic [DATA_W-1:0] r1_read_data,
  output logic              r1_done,
  output logic              r1_error,
  // shared memory bus
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_dispatch_read,
  output logic              mem_dispatch_write,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_done
);
  import mem_arbiter_pkg::*;

  // The wait counter holds completed WAIT cycles, so its largest value is TIMEOUT-1.
  localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state;
  state_t            state_next;
  logic              last_grant;
  logic              grant;
  logic              gnt_idx;
  op_t               op;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_error;
  logic [CNT_W-1:0]  wait_cnt;
  logic [1:0]        req_vec;
  logic              any_req;
  logic              grant_rd;
  logic              timeout_hit;

  assign req_vec     = {r1_read | r1_write, r0_read | r0_write};
  assign any_req     = |req_vec;
  assign grant_rd    = grant ? r1_read : r0_read;
  // Terminal WAIT cycle: this is the TIMEOUT-th cycle spent waiting.
  assign timeout_hit = (wait_cnt == CNT_LAST);

  rr_arbiter2 u_rr_arbiter2 (
    .req        (req_vec),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // State register; reset abandons any access in flight without a completion.
  always_ff @(posedge clk_in or negedge rst_in) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values, avoiding simulation races.
    if (!rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and all bus/requester outputs, which are pure functions of state.
  always_comb begin
    state_next         = state;
    mem_addr           = '0;
    mem_write_data     = '0;
    mem_dispatch_read  = 1'b0;
    mem_dispatch_write = 1'b0;
    r0_done            = 1'b0;
    r0_error           = 1'b0;
    r0_read_data       = '0;
    r1_done            = 1'b0;
    r1_error           = 1'b0;
    r1_read_data       = '0;

    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ISSUE;
        end
      end

      ISSUE: begin
        mem_addr           = lat_addr;
        mem_write_data     = lat_data;
        mem_dispatch_read  = (op == OP_READ);
        mem_dispatch_write = (op == OP_WRITE);
        state_next         = WAIT;
      end

      WAIT: begin
        mem_addr       = lat_addr;
        mem_write_data = lat_data;
        // mem_done wins over a coincident terminal count.
        if (mem_done || timeout_hit) begin
          state_next = RESPOND;
        end
      end

      RESPOND: begin
        if (gnt_idx) begin
          r1_done      = 1'b1;
          r1_error     = rsp_error;
          r1_read_data = rsp_data;
        end else begin
          r0_done      = 1'b1;
          r0_error     = rsp_error;
          r0_read_data = rsp_data;
        end
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // Grant capture: latch the winner's index, op, address and write data.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      gnt_idx  <= 1'b0;
      op       <= OP_READ;
      lat_addr <= '0;
      lat_data <= '0;
    end else if (state == IDLE && any_req) begin
      gnt_idx  <= grant;
      op       <= decode_op(grant_rd);
      lat_addr <= grant ? r1_addr : r0_addr;
      lat_data <= grant ? r1_write_data : r0_write_data;
    end
  end

  // WAIT-cycle counter: cleared on grant, advances on each WAIT cycle without mem_done.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
    end else if (state == WAIT && !mem_done && !timeout_hit) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Completion capture: read data on success, error flag on timeout.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rsp_data  <= '0;
      rsp_error <= 1'b0;
    end else if (state == IDLE) begin
      rsp_data  <= '0;
      rsp_error <= 1'b0;
    end else if (state == WAIT) begin
      if (mem_done) begin
        rsp_data  <= (op == OP_READ) ? mem_read_data : '0;
        rsp_error <= 1'b0;
      end else if (timeout_hit) begin
        rsp_data  <= '0;
        rsp_error <= 1'b1;
      end
    end
  end

  // Round-robin history moves only when a transaction actually completes.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      last_grant <= 1'b1;
    end else if (state == RESPOND) begin
      last_grant <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with literal expectations, then
// randomized requesters and memory, all checked every cycle against a
// transaction-level model (grant cycle + phase arithmetic).
module tb_mem_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 8;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] r_addr  [2];
  logic [DATA_W-1:0] r_wdata [2];
  logic              r_read  [2];
  logic              r_write [2];
  logic [DATA_W-1:0] d_rdata [2];
  logic              d_done  [2];
  logic              d_err   [2];
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_dispatch_read;
  logic              mem_dispatch_write;
  logic              mem_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: one in-flight transaction described by its grant cycle g.
  // Cycle g+1 dispatches, g+2.. wait, m_done_at is the completion cycle.
  bit                m_act     = 1'b0;
  int                m_who     = 0;
  bit                m_rd      = 1'b0;
  logic [ADDR_W-1:0] m_addr    = '0;
  logic [DATA_W-1:0] m_data    = '0;
  logic [DATA_W-1:0] m_rdata   = '0;
  bit                m_err     = 1'b0;
  int                m_g       = 0;
  int                m_done_at = -1;
  int                m_last    = 1;
  int                mem_plan  = -1;
  int                st [2];   // requester agent: 0 idle, 1 asking, 2 granted, 3 completed

  bit                exp_valid = 1'b0;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata;
  logic              e_dr;
  logic              e_dw;
  logic [DATA_W-1:0] e_rdata [2];
  logic              e_done  [2];
  logic              e_err   [2];

  mem_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_in             (clk),
    .rst_in             (rst_n),
    .r0_addr            (r_addr[0]),
    .r0_write_data      (r_wdata[0]),
    .r0_read            (r_read[0]),
    .r0_write           (r_write[0]),
    .r0_read_data       (d_rdata[0]),
    .r0_done            (d_done[0]),
    .r0_error           (d_err[0]),
    .r1_addr            (r_addr[1]),
    .r1_write_data      (r_wdata[1]),
    .r1_read            (r_read[1]),
    .r1_write           (r_write[1]),
    .r1_read_data       (d_rdata[1]),
    .r1_done            (d_done[1]),
    .r1_error           (d_err[1]),
    .mem_addr           (mem_addr),
    .mem_write_data     (mem_write_data),
    .mem_dispatch_read  (mem_dispatch_read),
    .mem_dispatch_write (mem_dispatch_write),
    .mem_read_data      (mem_read_data),
    .mem_done           (mem_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Move to the next cycle: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mem_done      = 1'b0;
    mem_read_data = DATA_W'($urandom);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 2; i++) begin
      r_read[i]  = 1'b0;
      r_write[i] = 1'b0;
      st[i]      = 0;
    end
  endtask

  // Expected outputs for the current cycle, then advance the model past its closing edge.
  task automatic eval();
    int ph;
    bit q0;
    bit q1;
    ph      = cyc - m_g;
    e_addr  = '0;
    e_wdata = '0;
    e_dr    = 1'b0;
    e_dw    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e_rdata[i] = '0;
      e_done[i]  = 1'b0;
      e_err[i]   = 1'b0;
    end
    exp_valid = 1'b1;
    if (!rst_n) begin
      m_act  = 1'b0;
      m_last = 1;
      return;
    end
    if (m_act) begin
      if (cyc == m_done_at) begin
        e_done[m_who]  = 1'b1;
        e_err[m_who]   = m_err;
        e_rdata[m_who] = m_rdata;
      end else begin
        e_addr  = m_addr;
        e_wdata = m_data;
        if (ph == 1) begin
          e_dr = m_rd;
          e_dw = !m_rd;
        end
      end
    end
    if (m_act && cyc == m_done_at) begin
      m_act  = 1'b0;
      m_last = m_who;
      if (st[m_who] == 2) st[m_who] = 3;
    end else if (m_act) begin
      if (ph >= 2) begin
        if (mem_done) begin
          m_done_at = cyc + 1;
          m_err     = 1'b0;
          m_rdata   = m_rd ? mem_read_data : '0;
        end else if (ph - 1 == TIMEOUT) begin
          m_done_at = cyc + 1;
          m_err     = 1'b1;
          m_rdata   = '0;
        end
      end
    end else begin
      q0 = r_read[0] | r_write[0];
      q1 = r_read[1] | r_write[1];
      if (q0 || q1) begin
        m_who     = (q0 && q1) ? 1 - m_last : (q0 ? 0 : 1);
        m_rd      = r_read[m_who];
        m_addr    = r_addr[m_who];
        m_data    = r_wdata[m_who];
        m_g       = cyc;
        m_done_at = -1;
        m_act     = 1'b1;
        if (st[m_who] == 1) st[m_who] = 2;
        mem_plan  = cyc + 1 + int'($urandom_range(TIMEOUT + 3, 1));
      end
    end
  endtask

  // Single compare process: every output against the model, away from the rising edge.
  always @(negedge clk) begin
    if (exp_valid) begin
      check("mem_addr", 32'(mem_addr), 32'(e_addr));
      check("mem_write_data", 32'(mem_write_data), 32'(e_wdata));
      check("mem_dispatch_read", 32'(mem_dispatch_read), 32'(e_dr));
      check("mem_dispatch_write", 32'(mem_dispatch_write), 32'(e_dw));
      for (int i = 0; i < 2; i++) begin
        check($sformatf("r%0d_done", i), 32'(d_done[i]), 32'(e_done[i]));
        check($sformatf("r%0d_error", i), 32'(d_err[i]), 32'(e_err[i]));
        check($sformatf("r%0d_read_data", i), 32'(d_rdata[i]), 32'(e_rdata[i]));
      end
    end
  end

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      rst_n = 1'b0;
      clear_reqs();
      eval();
      @(negedge clk);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_dispatch", 32'({mem_dispatch_read, mem_dispatch_write}), 0);
      check("rst_done", 32'({d_done[1], d_done[0]}), 0);
    end
    tick();
    rst_n = 1'b1;
    eval();
    @(negedge clk);
  endtask

  // cpu read of 0x1234; memory samples the dispatch at the edge closing
  // cycle 1 and answers two cycles later, so mem_done is high in cycle 4.
  task automatic run_read();
    for (int t = 0; t < 8; t++) begin
      tick();
      case (t)
        0: begin r_read[0] = 1'b1; r_addr[0] = 16'h1234; end
        4: begin mem_done = 1'b1; mem_read_data = 8'hA5; end
        6: r_read[0] = 1'b0;
        default: ;
      endcase
      eval();
      @(negedge clk);
      case (t)
        0: check("rd_idle_addr", 32'(mem_addr), 0);
        1: begin
          check("rd_dispatch", 32'(mem_dispatch_read), 1);
          check("rd_addr", 32'(mem_addr), 'h1234);
        end
        4: check("rd_not_yet", 32'(d_done[0]), 0);
        5: begin
          check("rd_done", 32'(d_done[0]), 1);
          check("rd_data", 32'(d_rdata[0]), 'hA5);
          check("rd_other_done", 32'(d_done[1]), 0);
        end
        default: ;
      endcase
    end
  endtask

  // Both requesters write from reset: r0 first, then r1, then alternation.
  task automatic run_tie();
    for (int t = 0; t < 18; t++) begin
      tick();
      case (t)
        0: begin
          r_write[0] = 1'b1; r_addr[0] = 16'h0010; r_wdata[0] = 8'h11;
          r_write[1] = 1'b1; r_addr[1] = 16'h00FF; r_wdata[1] = 8'h3C;
        end
        2, 6, 10, 14: mem_done = 1'b1;
        4:  r_write[0] = 1'b0;
        5:  begin r_write[0] = 1'b1; r_addr[0] = 16'h0030; r_wdata[0] = 8'h44; end
        12: r_write[0] = 1'b0;
        16: r_write[1] = 1'b0;
        default: ;
      endcase
      eval();
      @(negedge clk);
      case (t)
        1: begin
          check("tie_first_addr", 32'(mem_addr), 'h0010);
          check("tie_first_write", 32'(mem_dispatch_write), 1);
        end
        3: check("tie_r0_done", 32'({d_done[1], d_done[0]}), 'b01);
        4: check("tie_gap_idle", 32'(mem_addr), 0);
        5: begin
          check("tie_r1_addr", 32'(mem_addr), 'h00FF);
          check("tie_r1_wdata", 32'(mem_write_data), 'h3C);
          check("tie_r1_write", 32'({mem_dispatch_read, mem_dispatch_write}), 'b01);
        end
        6: check("tie_single_pulse", 32'(mem_dispatch_write), 0);
        7: check("tie_r1_done", 32'({d_done[1], d_done[0]}), 'b10);
        9: check("tie_alt_r0", 32'(mem_addr), 'h0030);
        13: check("tie_alt_r1", 32'(mem_addr), 'h00FF);
        default: ;
      endcase
    end
  endtask

  // Timeout after TIMEOUT wait cycles, then mem_done on the terminal cycle.
  task automatic run_timeout();
    for (int t = 0; t < 25; t++) begin
      tick();
      case (t)
        0:  begin r_read[0] = 1'b1; r_addr[0] = 16'hBEEF; end
        11: r_read[0] = 1'b0;
        12: begin r_read[0] = 1'b1; r_addr[0] = 16'h0101; end
        21: begin mem_done = 1'b1; mem_read_data = 8'h77; end
        23: r_read[0] = 1'b0;
        default: ;
      endcase
      eval();
      @(negedge clk);
      case (t)
        9:  check("to_not_yet", 32'(d_done[0]), 0);
        10: begin
          check("to_done_err", 32'({d_done[0], d_err[0]}), 'b11);
          check("to_data_zero", 32'(d_rdata[0]), 0);
        end
        22: begin
          check("edge_done_ok", 32'({d_done[0], d_err[0]}), 'b10);
          check("edge_data", 32'(d_rdata[0]), 'h77);
        end
        default: ;
      endcase
    end
  endtask

  // Read and write together from one requester is a read.
  task automatic run_both_ops();
    for (int t = 0; t < 5; t++) begin
      tick();
      case (t)
        0: begin r_read[0] = 1'b1; r_write[0] = 1'b1; r_addr[0] = 16'h0042; r_wdata[0] = 8'h99; end
        2: begin mem_done = 1'b1; mem_read_data = 8'h5A; end
        4: begin r_read[0] = 1'b0; r_write[0] = 1'b0; end
        default: ;
      endcase
      eval();
      @(negedge clk);
      case (t)
        1: check("both_is_read", 32'({mem_dispatch_read, mem_dispatch_write}), 'b10);
        3: check("both_rdata", 32'(d_rdata[0]), 'h5A);
        default: ;
      endcase
    end
  endtask

  // Reset during WAIT, mem_done after release: nothing completes.
  task automatic run_reset_wait();
    for (int t = 0; t < 9; t++) begin
      tick();
      case (t)
        0: begin r_read[0] = 1'b1; r_addr[0] = 16'h0777; end
        3: begin rst_n = 1'b0; r_read[0] = 1'b0; end
        5: begin rst_n = 1'b1; mem_done = 1'b1; end
        default: ;
      endcase
      eval();
      @(negedge clk);
      case (t)
        2: check("rw_waiting_addr", 32'(mem_addr), 'h0777);
        6, 7: begin
          check("rw_no_done", 32'({d_done[1], d_done[0]}), 0);
          check("rw_idle_addr", 32'(mem_addr), 0);
        end
        default: ;
      endcase
    end
  endtask

  task automatic run_random(input int n);
    int op;
    int rst_cnt;
    rst_cnt = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) rst_n = 1'b1;
      end else if ($urandom_range(499) == 0) begin
        rst_n   = 1'b0;
        rst_cnt = 2;
        clear_reqs();
      end
      if (rst_n) begin
        for (int i = 0; i < 2; i++) begin
          case (st[i])
            3: begin r_read[i] = 1'b0; r_write[i] = 1'b0; st[i] = 0; end
            2: if ($urandom_range(7) == 0) begin r_read[i] = 1'b0; r_write[i] = 1'b0; end
            0: if ($urandom_range(2) == 0) begin
              op         = int'($urandom_range(2));
              r_read[i]  = (op != 1);
              r_write[i] = (op != 0);
              r_addr[i]  = ADDR_W'($urandom);
              r_wdata[i] = DATA_W'($urandom);
              st[i]      = 1;
            end
            default: ;
          endcase
        end
        mem_done = (cyc == mem_plan) || ($urandom_range(39) == 0);
      end
      eval();
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      r_addr[i]  = '0;
      r_wdata[i] = '0;
      r_read[i]  = 1'b0;
      r_write[i] = 1'b0;
      st[i]      = 0;
    end
    mem_done      = 1'b0;
    mem_read_data = '0;
    do_reset(3);
    run_read();
    do_reset(2);
    run_tie();
    run_timeout();
    run_both_ops();
    run_reset_wait();
    do_reset(2);
    run_random(4000);
    tick();
    clear_reqs();
    eval();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 Parameter TIMEOUT, default 255, max cycles in WAIT before an error completion.
REQ-004 clk_in  input  1  single clock; all logic rising-edge.
REQ-005 rst_in  input  1  asynchronous, active-low reset.
REQ-006 rN_addr  input  ADDR_W  requester N address, N in {0,1}; 0 = cpu, 1 = video/DMA.
REQ-007 rN_write_data  input  DATA_W  requester N write data.
REQ-008 rN_read  input  1  requester N read request, level, held until rN_done.
REQ-009 rN_write  input  1  requester N write request, level, held until rN_done.
REQ-010 rN_read_data  output  DATA_W  read result, valid while rN_done high.
REQ-011 rN_done  output  1  one-cycle completion pulse.
REQ-012 rN_error  output  1  high with rN_done when the access timed out.
REQ-013 mem_addr  output  ADDR_W  shared memory bus address.
REQ-014 mem_write_data  output  DATA_W  shared memory bus write data.
REQ-015 mem_dispatch_read  output  1  one-cycle read dispatch pulse.
REQ-016 mem_dispatch_write  output  1  one-cycle write dispatch pulse.
REQ-017 mem_read_data  input  DATA_W  read data from memory, valid with mem_done.
REQ-018 mem_done  input  1  one-cycle completion from memory.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, RESPOND; exactly one transaction outstanding at any time.
REQ-020 IDLE: if any rN_read|rN_write high, grant one requester, latch its addr, data, op and grant index, go ISSUE; else stay.
REQ-021 Arbitration round-robin: with both requesting, grant the requester not granted last; last_grant resets to 1 so r0 wins the first tie.
REQ-022 rN_read and rN_write both high from one requester: treated as read.
REQ-023 ISSUE: for exactly one cycle drive mem_dispatch_read or mem_dispatch_write per latched op; go WAIT. Dispatch occurs the cycle after grant.
REQ-024 mem_addr and mem_write_data hold latched values from ISSUE through WAIT; zero in IDLE.
REQ-025 WAIT: on mem_done, capture mem_read_data (reads only), go RESPOND; mem_done in any other state is ignored.
REQ-026 WAIT counter increments each WAIT cycle; reaching TIMEOUT without mem_done goes RESPOND with error set and read data 0.
REQ-027 RESPOND: pulse done (and error if set) to the granted requester only for one cycle, drive captured read data, update last_grant, go IDLE.
REQ-028 Non-granted requester's done, error, read_data are 0 at all times.
REQ-029 Requester dropping its request after grant does not abort the transaction; completion still pulses.
REQ-030 Minimum latency request->done = 3 cycles plus memory latency; back-to-back grants separated by one IDLE cycle.
REQ-031 mem_done coincident with timeout terminal count: treated as success.

Reset
REQ-032 rst_in low asynchronously forces IDLE, last_grant = 1, counter = 0, all outputs 0.
REQ-033 Reset mid-transaction drops the access silently; no done pulse issued after release.

Structure
REQ-034 Shared package holds the FSM state enum and the op enum (OP_READ, OP_WRITE).
REQ-035 One sub-module, rr_arbiter2: two request bits, last_grant in, grant index out, combinational.

Verification
REQ-036 r0_read addr 0x1234, memory done 2 cycles after dispatch with 0xA5 -> mem_dispatch_read at cycle+1, r0_done with r0_read_data 0xA5 at cycle+5.
REQ-037 r0 and r1 write simultaneously from reset -> r0 served first, r1 dispatched after r0_done plus one IDLE cycle; repeat -> alternates.
REQ-038 r1_write addr 0x00FF data 0x3C -> mem_addr 0x00FF, mem_write_data 0x3C, single mem_dispatch_write pulse.
REQ-039 r0_read, mem_done never asserted, TIMEOUT 8 -> r0_done and r0_error high together after 8 WAIT cycles, read data 0.
REQ-040 rst_in low during WAIT, then mem_done after release -> no rN_done, FSM in IDLE, outputs 0.
REQ-041 r0 asserts read and write together -> only mem_dispatch_read pulses.
